// File: rtl/fft_pkg.sv
// Shared FFT stream types: complex sample layout, magnitude width and a squaring helper.
package fft_pkg;

  localparam int CPLX_W       = 32;
  localparam int SAMPLE_W     = 16;
  localparam int MAG_W        = 32;
  localparam int SQ_W         = 31;
  localparam int FFT_SIZE_DEF = 2048;
  localparam int BIN_W        = $clog2(FFT_SIZE_DEF);

  typedef logic [BIN_W-1:0] bin_idx_t;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] im;
    logic signed [SAMPLE_W-1:0] re;
  } cplx_t;

  // Largest square is (-32768)^2 = 2^30, so 31 unsigned bits always suffice.
  function automatic logic [SQ_W-1:0] sq16(input logic signed [SAMPLE_W-1:0] x);
    logic signed [2*SAMPLE_W-1:0] p;
    p = x * x;
    return p[SQ_W-1:0];
  endfunction

endpackage

// File: rtl/fft_cplx_sq.sv
// Two-stage |X|^2 = re^2 + im^2 pipeline with a shared enable and a pass-through sideband.
module fft_cplx_sq
  import fft_pkg::*;
#(
  parameter int SB_W  = 1,
  parameter int SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  cplx_t             in_data,
  input  logic [SB_W-1:0]   in_sb,
  output logic              out_valid,
  output logic [MAG_W-1:0]  out_mag,
  output logic [SB_W-1:0]   out_sb
);

  logic            s1_valid_q, s1_valid_d;
  logic [SQ_W-1:0] re_sq_q, re_sq_d;
  logic [SQ_W-1:0] im_sq_q, im_sq_d;
  logic [SB_W-1:0] s1_sb_q, s1_sb_d;
  logic            valid_q, valid_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [SB_W-1:0] sb_q, sb_d;
  logic [MAG_W-1:0] sum_s;

  assign sum_s = {1'b0, re_sq_q} + {1'b0, im_sq_q};

  always_comb begin
    s1_valid_d = s1_valid_q;
    re_sq_d    = re_sq_q;
    im_sq_d    = im_sq_q;
    s1_sb_d    = s1_sb_q;
    valid_d    = valid_q;
    mag_d      = mag_q;
    sb_d       = sb_q;
    if (en) begin
      s1_valid_d = in_valid;
      re_sq_d    = sq16(in_data.re);
      im_sq_d    = sq16(in_data.im);
      s1_sb_d    = in_sb;
      valid_d    = s1_valid_q;
      mag_d      = sum_s >> SHIFT;
      sb_d       = s1_sb_q;
    end else begin
      s1_valid_d = s1_valid_q;
      valid_d    = valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      re_sq_q    <= '0;
      im_sq_q    <= '0;
      s1_sb_q    <= '0;
      valid_q    <= 1'b0;
      mag_q      <= '0;
      sb_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      re_sq_q    <= re_sq_d;
      im_sq_q    <= im_sq_d;
      s1_sb_q    <= s1_sb_d;
      valid_q    <= valid_d;
      mag_q      <= mag_d;
      sb_q       <= sb_d;
    end
  end

  assign out_valid = valid_q;
  assign out_mag   = mag_q;
  assign out_sb    = sb_q;

endmodule

// File: rtl/fft_output_magnitude.sv
// FFT output stage: per-bin |X|^2 stream with bin index and frame-alignment checking.
// Optional build macro FFT_OUT_HALF_SPECTRUM_EN forwards only bins 0..FFT_SIZE/2-1.
module fft_output_magnitude
  import fft_pkg::*;
#(
  parameter  int FFT_SIZE  = 2048,
  parameter  int MAG_SHIFT = 0,
  localparam int CW        = $clog2(FFT_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CPLX_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [MAG_W-1:0]  m_mag,
  output logic [CW-1:0]     m_bin,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          frame_err_q, frame_err_d;
  logic          adv_s, acc_s, cnt_end_s, fwd_s, last_s;
  logic [CW:0]   out_sb_s;

  assign adv_s     = !m_valid | m_ready;
  assign acc_s     = s_tvalid & adv_s;
  assign cnt_end_s = (cnt_q == CW'(FFT_SIZE - 1));

`ifdef FFT_OUT_HALF_SPECTRUM_EN
  assign fwd_s  = (cnt_q < CW'(FFT_SIZE / 2));
  assign last_s = (cnt_q == CW'(FFT_SIZE / 2 - 1)) | s_tlast;
`else
  assign fwd_s  = 1'b1;
  assign last_s = cnt_end_s | s_tlast;
`endif

  // Any framing violation resynchronises the counter to 0 without counting a frame.
  always_comb begin
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = 1'b0;
    if (acc_s) begin
      if (s_tlast) begin
        cnt_d = '0;
        if (cnt_end_s) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else if (cnt_end_s) begin
        cnt_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      frame_cnt_q <= 16'd0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  fft_cplx_sq #(
    .SB_W  (CW + 1),
    .SHIFT (MAG_SHIFT)
  ) u_sq (
    .clk       (clk),
    .reset     (reset),
    .en        (adv_s),
    .in_valid  (acc_s & fwd_s),
    .in_data   (cplx_t'(s_tdata)),
    .in_sb     ({cnt_q, last_s}),
    .out_valid (m_valid),
    .out_mag   (m_mag),
    .out_sb    (out_sb_s)
  );

  assign m_bin     = out_sb_s[CW:1];
  assign m_last    = out_sb_s[0];
  assign s_tready  = adv_s;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_output_magnitude.sv
// Directed + randomized bench for fft_output_magnitude against a queue-based reference model.
module tb_fft_output_magnitude;

  localparam int N  = 16;
  localparam int SH = 0;
  localparam int CW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [31:0]   m_mag;
  logic [CW-1:0] m_bin;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          frame_err;
  logic [15:0]   frame_cnt;

  fft_output_magnitude #(.FFT_SIZE(N), .MAG_SHIFT(SH)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_mag(m_mag), .m_bin(m_bin), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint mag;
    int     bin;
    bit     last;
    int     edge_no;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_cnt = 0;
  int          cnt_m = 0;
  logic [15:0] frame_exp = 16'd0;
  bit          lat_chk = 1'b1;
  bit          hold_v = 1'b0;
  logic [31:0] hold_mag;
  logic [CW-1:0] hold_bin;
  logic        hold_last;

`ifdef FFT_OUT_HALF_SPECTRUM_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: magnitude by plain integer arithmetic, framing by the stated counting rules.
  task automatic model_accept(input logic [31:0] d, input logic l, output bit err);
    int     re, im;
    longint mag;
    int     last_fwd;
    exp_t   e;
    re       = int'($signed(d[15:0]));
    im       = int'($signed(d[31:16]));
    mag      = (longint'(re) * re + longint'(im) * im) >>> SH;
    last_fwd = HALF ? (N / 2 - 1) : (N - 1);
    if (!HALF || cnt_m < N / 2) begin
      e.mag = mag; e.bin = cnt_m; e.last = (cnt_m == last_fwd) || l; e.edge_no = edge_cnt;
      exp_q.push_back(e);
    end
    err = 1'b0;
    if (l) begin
      if (cnt_m == N - 1) frame_exp = frame_exp + 16'd1;
      else err = 1'b1;
      cnt_m = 0;
    end else if (cnt_m == N - 1) begin
      err = 1'b1;
      cnt_m = 0;
    end else begin
      cnt_m = cnt_m + 1;
    end
  endtask

  // One clock: drive at negedge, check outputs before the edge, update model at the edge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic l, input logic r,
                     output bit acc);
    exp_t e;
    bit   err_e;
    s_tvalid = v; s_tdata = d; s_tlast = l; m_ready = r;
    #1;
    chk("s_tready", s_tready, !m_valid || r);
    if (hold_v) begin
      chk("hold_valid", m_valid, 1'b1);
      chk("hold_mag", m_mag, hold_mag);
      chk("hold_bin", m_bin, hold_bin);
      chk("hold_last", m_last, hold_last);
    end
    hold_v = m_valid && !r;
    hold_mag = m_mag; hold_bin = m_bin; hold_last = m_last;
    if (m_valid && r) begin
      chk("out_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_mag", m_mag, e.mag);
        chk("m_bin", m_bin, e.bin);
        chk("m_last", m_last, e.last);
        if (lat_chk) chk("latency", (edge_cnt + 1) - e.edge_no, 2);
      end
    end
    acc = v && s_tready;
    @(posedge clk);
    edge_cnt++;
    err_e = 1'b0;
    if (acc) model_accept(d, l, err_e);
    #1;
    chk("frame_err", frame_err, err_e);
    chk("frame_cnt", frame_cnt, frame_exp);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, acc);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, acc);
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_mag"}, m_mag, 32'd0);
    chk({tag, "_m_bin"}, m_bin, 0);
    chk({tag, "_m_last"}, m_last, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_frame_cnt"}, frame_cnt, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sent;
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = 32'd0; s_tlast = 1'b0; m_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

`ifdef FFT_OUT_HALF_SPECTRUM_EN
    // Half spectrum: only bins 0..7 forwarded, input never back-pressured.
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, {16'h0001, 16'(k)}, k == N - 1, 1'b1, acc);
      chk("half_tready", acc, 1'b1);
    end
    drain();
    chk("half_frame_cnt", frame_cnt, 16'd1);
`else
    // Ramp frame, im=0, re=k.
    for (int k = 0; k < N; k++) cyc(1'b1, {16'h0000, 16'(k)}, k == N - 1, 1'b1, acc);
    drain();
    chk("t1_frame_cnt", frame_cnt, 16'd1);

    // Extreme magnitudes.
    cyc(1'b1, 32'h8000_8000, 1'b0, 1'b1, acc);
    cyc(1'b1, {16'hFFFC, 16'h0003}, 1'b0, 1'b1, acc);
    drain();

    // Early tlast at bin 9 (bins 2..9 here), then missing tlast at bin 15, then a clean frame.
    for (int k = 2; k <= 9; k++) cyc(1'b1, 32'($urandom), k == 9, 1'b1, acc);
    for (int k = 0; k < N; k++) cyc(1'b1, 32'($urandom), 1'b0, 1'b1, acc);
    for (int k = 0; k < N; k++) cyc(1'b1, 32'($urandom), k == N - 1, 1'b1, acc);
    drain();
    chk("t4_frame_cnt", frame_cnt, 16'd2);

    // Random valid and sparse ready over three frames.
    lat_chk = 1'b0;
    sent = 0;
    for (int c = 0; c < 3000 && sent < 3 * N; c++) begin
      cyc(1'($urandom_range(0, 1)), 32'($urandom), (sent % N) == N - 1,
          ($urandom_range(0, 2) == 0), acc);
      if (acc) sent++;
    end
    chk("t3_sent", sent, 3 * N);
    drain();
    chk("t3_frame_cnt", frame_cnt, 16'd5);
    lat_chk = 1'b1;

    // Reset mid-frame while a beat sits in the output register.
    cyc(1'b1, 32'h0005_0007, 1'b0, 1'b1, acc);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, acc);
    chk("t5_pre_valid", m_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk_zero("t5");
    exp_q.delete(); cnt_m = 0; frame_exp = 16'd0; hold_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cyc(1'b1, {16'h0002, 16'h0006}, 1'b0, 1'b1, acc);
    cyc(1'b1, {16'h0000, 16'h0001}, 1'b0, 1'b1, acc);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
